// File: rtl/nonce_scheduler_pkg.sv
// Shared types and SHA-256 padding constants for the nonce scheduler and its FIFO.
// Build option: NONCE_SCHEDULER_TARGET_CMP_EN (consumed by nonce_scheduler.sv).
package nonce_scheduler_pkg;

    localparam logic [31:0] SHA_PAD_BIT = 32'h8000_0000;
    localparam logic [31:0] SHA_LEN_640 = 32'h0000_0280;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef logic [31:0] nonce_t;

    // Second 64-byte chunk of the 80-byte header, word0 in the low bits.
    function automatic logic [511:0] build_data1(input nonce_t nonce, input logic [95:0] tail);
        return {SHA_LEN_640, 320'h0, SHA_PAD_BIT, nonce, tail};
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous valid/ready FIFO with a full flag; a push while full is accepted only
// when a pop retires the head in the same cycle.
module nonce_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push_ok;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop     = o_valid && i_ready;
    assign w_push_ok = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; r_count alone says which entries are live.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Walks an inclusive (wrapping) nonce range into a double-SHA256 pipeline and queues golden nonces.
// Build option NONCE_SCHEDULER_TARGET_CMP_EN: full 256-bit target compare; otherwise difficulty-1.
module nonce_scheduler
    import nonce_scheduler_pkg::*;
#(
    parameter int LATENCY    = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         work_valid,
    output logic         work_ready,
    input  logic [255:0] midstate,
    input  logic [95:0]  data_tail,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic [255:0] hash0,
    output logic [511:0] data1,
    input  logic [255:0] hash2,
    output logic         golden_valid,
    input  logic         golden_ready,
    output logic [31:0]  golden_nonce,
    output logic         busy,
    output logic         done,
    output logic         drop
);
    state_t           r_state;
    nonce_t           r_nonce;
    nonce_t           r_nonce_end;
    logic [95:0]      r_tail;
    logic [255:0]     r_hash0;
    logic [511:0]     r_data1;
    logic             r_done;
    logic [LATENCY:0] r_sl_valid;
    nonce_t           r_sl_nonce [LATENCY+1];
    logic             r_cmp_valid;
    nonce_t           r_cmp_nonce;

    logic             w_issue;
    logic             w_line_empty;
    logic             w_hash_hit;
    logic             w_fifo_full;
    logic             w_fifo_valid;
    nonce_t           w_fifo_nonce;

    assign w_issue      = (r_state == ST_RUN);
    assign w_line_empty = (r_sl_valid == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hash0 <= '0;
            r_data1 <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (work_valid) begin
                        r_state <= ST_RUN;
                        r_hash0 <= midstate;
                    end
                end
                ST_RUN: begin
                    r_data1 <= build_data1(r_nonce, r_tail);
                    if (r_nonce == r_nonce_end) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // An empty line now means the compare register is empty after this edge.
                    if (w_line_empty) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && work_valid) begin
            r_nonce     <= nonce_start;
            r_nonce_end <= nonce_end;
            r_tail      <= data_tail;
        end else if (w_issue) begin
            r_nonce <= r_nonce + 32'd1;
        end
    end

`ifdef NONCE_SCHEDULER_TARGET_CMP_EN
    logic [255:0] r_target;

    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && work_valid) r_target <= target;
    end

    assign w_hash_hit = (hash2 <= r_target);
`else
    logic w_unused_inputs;

    assign w_unused_inputs = ^{target, hash2[223:0]};
    assign w_hash_hit      = (hash2[255:224] == 32'h0);
`endif

    // Stage 0 is loaded alongside data1; stage LATENCY lines up with the matching hash2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sl_valid  <= '0;
            r_cmp_valid <= 1'b0;
        end else begin
            r_sl_valid  <= {r_sl_valid[LATENCY-1:0], w_issue};
            r_cmp_valid <= r_sl_valid[LATENCY] && w_hash_hit;
        end
    end

    always_ff @(posedge clk) begin
        r_sl_nonce[0] <= r_nonce;
        for (int i = 1; i <= LATENCY; i++) r_sl_nonce[i] <= r_sl_nonce[i-1];
        r_cmp_nonce <= r_sl_nonce[LATENCY];
    end

    nonce_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_cmp_valid),
        .i_data  (r_cmp_nonce),
        .o_full  (w_fifo_full),
        .o_valid (w_fifo_valid),
        .i_ready (golden_ready),
        .o_data  (w_fifo_nonce)
    );

    // Drop flags the very cycle a golden is refused, so it is combinational on golden_ready.
    assign drop         = r_cmp_valid && w_fifo_full && !golden_ready;
    assign golden_valid = w_fifo_valid;
    assign golden_nonce = w_fifo_valid ? w_fifo_nonce : '0;
    assign work_ready   = (r_state == ST_IDLE);
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign hash0        = r_hash0;
    assign data1        = r_data1;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler with a LATENCY=4 hash stub and a queue-based result model.
// Works with or without NONCE_SCHEDULER_TARGET_CMP_EN; the golden rule follows the same macro.
module tb_nonce_scheduler;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         work_valid = 1'b0;
    logic         work_ready;
    logic [255:0] midstate = '0;
    logic [95:0]  data_tail = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] hash0;
    logic [511:0] data1;
    logic [255:0] hash2 = '0;
    logic         golden_valid;
    logic         golden_ready = 1'b0;
    logic [31:0]  golden_nonce;
    logic         busy;
    logic         done;
    logic         drop;

    int           errors = 0;
    int           checks = 0;
    logic [255:0] g_target;
    logic [255:0] g_h_miss;
    logic [255:0] hash_map [logic [31:0]];
    logic [31:0]  g_popped [$];
    int           g_drops;

    nonce_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
        .midstate(midstate), .data_tail(data_tail), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .hash0(hash0), .data1(data1),
        .hash2(hash2), .golden_valid(golden_valid), .golden_ready(golden_ready),
        .golden_nonce(golden_nonce), .busy(busy), .done(done), .drop(drop)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        logic [255:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    function automatic logic [255:0] hash_of(input logic [31:0] n);
        if (hash_map.exists(n)) return hash_map[n];
        return g_h_miss;
    endfunction

    function automatic bit model_golden(input logic [255:0] h);
`ifdef NONCE_SCHEDULER_TARGET_CMP_EN
        return h <= g_target;
`else
        return h[255:224] == 32'h0;
`endif
    endfunction

    // mode: 0 ready low, 1 ready high, 2 random, 3 low until done then high. abort_c>0 asserts rst there.
    task automatic run_job(input logic [31:0] start, input logic [31:0] stop, input int mode, input int abort_c);
        logic [31:0]  nq [$];
        logic [31:0]  fq [$];
        logic [31:0]  n;
        logic [31:0]  exp_nonce;
        logic [255:0] mid;
        logic [95:0]  tail;
        logic [511:0] exp_d1;
        int           nn, t_last, d_cyc, k;
        bit           g_here, pop, drop_exp;
        n = start;
        forever begin
            nq.push_back(n);
            if (n == stop) break;
            n = n + 32'd1;
        end
        nn = nq.size();
        t_last = nn + 1;
        d_cyc = nn + LAT + 3;
        mid = rand256();
        tail = {32'($urandom), 32'($urandom), 32'($urandom)};
        g_popped.delete();
        g_drops = 0;

        @(negedge clk);
        work_valid = 1'b1; midstate = mid; data_tail = tail; target = g_target;
        nonce_start = start; nonce_end = stop; hash2 = '0; golden_ready = (mode == 1);
        #1;
        checks++;
        if (work_ready !== 1'b1) begin
            errors++; $display("FAIL handshake_ready: got %b expected 1", work_ready);
        end

        for (int c = 1; c < d_cyc + 64; c++) begin
            @(negedge clk);
            if (c < t_last) begin
                work_valid = 1'($urandom); midstate = rand256(); target = rand256();
                data_tail = {32'($urandom), 32'($urandom), 32'($urandom)};
                nonce_start = $urandom; nonce_end = $urandom;
            end else begin
                work_valid = 1'b0;
            end
            k = c - LAT - 2;
            hash2 = (k >= 0 && k < nn) ? hash_of(nq[k]) : '0;
            case (mode)
                1:       golden_ready = 1'b1;
                2:       golden_ready = 1'($urandom);
                3:       golden_ready = (c > d_cyc);
                default: golden_ready = 1'b0;
            endcase
            #1;
            checks++;
            if (busy !== (c < d_cyc)) begin
                errors++; $display("FAIL busy c=%0d: got %b expected %b", c, busy, c < d_cyc);
            end
            checks++;
            if (work_ready !== (c >= d_cyc)) begin
                errors++; $display("FAIL work_ready c=%0d: got %b expected %b", c, work_ready, c >= d_cyc);
            end
            checks++;
            if (done !== (c == d_cyc)) begin
                errors++; $display("FAIL done c=%0d: got %b expected %b", c, done, c == d_cyc);
            end
            if (c >= 2 && c <= t_last) begin
                exp_d1 = {32'h0000_0280, 320'h0, 32'h8000_0000, nq[c-2], tail};
                checks++;
                if (data1 !== exp_d1) begin
                    errors++; $display("FAIL data1 c=%0d: got %h expected %h", c, data1, exp_d1);
                end
                checks++;
                if (hash0 !== mid) begin
                    errors++; $display("FAIL hash0 c=%0d: got %h expected %h", c, hash0, mid);
                end
            end
            checks++;
            if (golden_valid !== (fq.size() > 0)) begin
                errors++; $display("FAIL golden_valid c=%0d: got %b expected %b", c, golden_valid, fq.size() > 0);
            end
            exp_nonce = (fq.size() > 0) ? fq[0] : 32'h0;
            checks++;
            if (golden_nonce !== exp_nonce) begin
                errors++; $display("FAIL golden_nonce c=%0d: got %h expected %h", c, golden_nonce, exp_nonce);
            end
            k = c - LAT - 3;
            g_here = (k >= 0 && k < nn) && model_golden(hash_of(nq[k]));
            pop = (fq.size() > 0) && golden_ready;
            drop_exp = g_here && (fq.size() == DEPTH) && !pop;
            checks++;
            if (drop !== drop_exp) begin
                errors++; $display("FAIL drop c=%0d: got %b expected %b", c, drop, drop_exp);
            end
            if (drop === 1'b1) g_drops++;
            if (golden_valid === 1'b1 && golden_ready) g_popped.push_back(golden_nonce);
            if (pop) void'(fq.pop_front());
            if (g_here && !drop_exp) fq.push_back(nq[k]);
            if (c == abort_c) begin
                rst = 1'b1;
                break;
            end
            if (c >= d_cyc && (fq.size() == 0 || mode == 0)) break;
        end
        if (abort_c == 0 && mode != 0) begin
            checks++;
            if (fq.size() != 0) begin
                errors++; $display("FAIL drain_budget: got %0d entries left expected 0", fq.size());
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (work_ready !== 1'b1) begin errors++; $display("FAIL reset_work_ready: got %b expected 1", work_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop); end
        checks++; if (golden_valid !== 1'b0) begin errors++; $display("FAIL reset_golden_valid: got %b expected 0", golden_valid); end
        checks++; if (golden_nonce !== 32'h0) begin errors++; $display("FAIL reset_golden_nonce: got %h expected 0", golden_nonce); end
        checks++; if (hash0 !== 256'h0) begin errors++; $display("FAIL reset_hash0: got %h expected 0", hash0); end
        checks++; if (data1 !== 512'h0) begin errors++; $display("FAIL reset_data1: got %h expected 0", data1); end
        rst = 1'b0;
    endtask

    task automatic test_basic_range();
        g_target = rand256(); g_h_miss = 256'h1 << 255; hash_map.delete();
        run_job(32'd5, 32'd7, 1, 0);
    endtask

    task automatic test_wrap();
        g_target = rand256(); g_h_miss = 256'h1 << 255; hash_map.delete();
        run_job(32'hFFFF_FFFE, 32'h0000_0001, 1, 0);
    endtask

    task automatic test_single();
        g_target = {32'h0, {224{1'b1}}}; g_h_miss = {32'h1, 224'h0}; hash_map.delete();
        hash_map[32'd77] = g_target;
        run_job(32'd77, 32'd77, 1, 0);
        checks++;
        if (g_popped.size() != 1 || g_popped[0] !== 32'd77) begin
            errors++; $display("FAIL single_golden: got %0d results expected 1 (77)", g_popped.size());
        end
    endtask

    task automatic test_target_boundary();
        g_target = {32'h0, {224{1'b1}}}; g_h_miss = g_target + 256'd1; hash_map.delete();
        hash_map[32'd6] = g_target;
        run_job(32'd5, 32'd7, 1, 0);
        checks++;
        if (g_popped.size() != 1 || g_popped[0] !== 32'd6) begin
            errors++; $display("FAIL boundary_golden: got %0d results expected 1 (6)", g_popped.size());
        end
    endtask

    task automatic test_overflow();
        g_target = {32'h0, {224{1'b1}}}; g_h_miss = {32'h1, 224'h0}; hash_map.delete();
        for (int i = 100; i <= 105; i++) hash_map[32'(i)] = 256'h0;
        run_job(32'd100, 32'd105, 3, 0);
        checks++;
        if (g_drops != 2) begin errors++; $display("FAIL overflow_drops: got %0d expected 2", g_drops); end
        checks++;
        if (g_popped.size() != DEPTH) begin
            errors++; $display("FAIL overflow_kept: got %0d expected %0d", g_popped.size(), DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (g_popped[i] !== 32'(100 + i)) begin
                    errors++; $display("FAIL overflow_order[%0d]: got %0d expected %0d", i, g_popped[i], 100 + i);
                end
            end
        end
    endtask

    task automatic test_reset_drain();
        g_target = {32'h0, {224{1'b1}}}; g_h_miss = {32'h1, 224'h0}; hash_map.delete();
        for (int i = 10; i <= 12; i++) hash_map[32'(i)] = 256'h0;
        run_job(32'd10, 32'd12, 0, 8);
        @(negedge clk);
        #1;
        checks++; if (golden_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_golden_valid: got %b expected 0", golden_valid); end
        checks++; if (work_ready !== 1'b1) begin errors++; $display("FAIL rst_drain_work_ready: got %b expected 1", work_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain_busy: got %b expected 0", busy); end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            golden_ready = 1'b1; hash2 = '0;
            #1;
            checks++;
            if (golden_valid !== 1'b0 || done !== 1'b0 || drop !== 1'b0) begin
                errors++; $display("FAIL post_rst_quiet c=%0d: got v=%b d=%b drop=%b expected all 0", c, golden_valid, done, drop);
            end
        end
    endtask

    task automatic test_difficulty();
        logic [255:0] h;
        int exp_n;
        g_target = '0; g_h_miss = {32'hFFFF_FFFF, 224'h0}; hash_map.delete();
        h = {32'h0, {224{1'b1}}};
        hash_map[32'd42] = h;
        exp_n = model_golden(h) ? 1 : 0;
        run_job(32'd41, 32'd43, 1, 0);
        checks++;
        if (g_popped.size() != exp_n || (exp_n == 1 && g_popped[0] !== 32'd42)) begin
            errors++; $display("FAIL difficulty_golden: got %0d results expected %0d", g_popped.size(), exp_n);
        end
    endtask

    task automatic test_random();
        logic [31:0] start, n;
        int len;
        for (int it = 0; it < 6; it++) begin
            start = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 6)) : $urandom;
            len = $urandom_range(1, 10);
            g_target = rand256();
            g_target[255:254] = 2'b01;
            g_h_miss = rand256();
            hash_map.delete();
            n = start;
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 4))
                    0:       hash_map[n] = g_target;
                    1:       hash_map[n] = g_target + 256'd1;
                    2:       hash_map[n] = g_target - 256'd1;
                    3:       hash_map[n] = {32'h0, rand256() >> 32};
                    default: hash_map[n] = rand256();
                endcase
                n = n + 32'd1;
            end
            run_job(start, start + 32'(len - 1), 2, 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_range();
        test_wrap();
        test_single();
        test_target_boundary();
        test_overflow();
        test_reset_drain();
        test_difficulty();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter LATENCY, default 128: fixed cycle count from data1 issue to matching hash2 from the downstream double-SHA256 pipeline; legal 1..1023.
REQ-002 Parameter FIFO_DEPTH, default 4: golden-nonce buffer entries; power of two, 2..16.
REQ-003 Clocking and reset: one clock, clk; reset is synchronous and active-high, named rst.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 work_valid  in  1  new work offered.
REQ-007 work_ready  out  1  high only in IDLE.
REQ-008 midstate  in  256  first-chunk SHA-256 state.
REQ-009 data_tail  in  96  merkle tail, time, bits; word0 at [31:0].
REQ-010 target  in  256  unsigned share target.
REQ-011 nonce_start, nonce_end  in  32 each  inclusive nonce range.
REQ-012 hash0  out  256  registered midstate to the hash core.
REQ-013 data1  out  512  registered second chunk to the hash core.
REQ-014 hash2  in  256  hash core result, unsigned integer, MSB = most significant byte.
REQ-015 golden_valid, golden_ready, golden_nonce  out/in/out  1/1/32  result stream, valid/ready.
REQ-016 busy, done, drop  out  1 each  status; done and drop are single-cycle pulses.

Function
REQ-017 States: IDLE, RUN, DRAIN.
- IDLE -> RUN on work_valid, which is the handshake cycle: latch midstate, data_tail, target and the nonce range; set nonce := nonce_start.
REQ-018 RUN behaviour:
- Each cycle, issue one nonce.
- data1 = {32'h00000280, 320'h0, 32'h80000000, nonce, data_tail}, word0 at [31:0].
- hash0 = latched midstate.
- After issuing nonce_end, go to DRAIN.
REQ-019 nonce_start > nonce_end is legal; the range wraps through 32'hFFFFFFFF to 0 and ends at nonce_end.
REQ-020 nonce_start == nonce_end issues exactly one nonce.
REQ-021 Issued nonces and issue-valid bits are delayed LATENCY cycles in a shift line; a delayed valid marks the cycle whose hash2 belongs to the delayed nonce.
REQ-022 Golden when hash2 <= target (full 256-bit unsigned compare, registered; adds one cycle before the FIFO push).
REQ-023 DRAIN lasts until the shift line and compare register are empty, then go to IDLE with done pulsed for one cycle.
REQ-024 busy is high in RUN and DRAIN.
REQ-025 Pipeline never stalls. A golden result arriving with the FIFO full is discarded and drop pulses for that cycle.
REQ-026 Simultaneous FIFO push and pop when full: the pop frees the slot and the push is accepted with no drop.
REQ-027 FIFO output: golden_valid = not empty; the entry retires when golden_valid and golden_ready are both high. FIFO order is preserved.
REQ-028 work_valid outside IDLE is ignored; work_ready is low.

Reset
REQ-029 On rst:
- state = IDLE; work_ready = 1.
- busy, done, drop, golden_valid = 0.
- FIFO empty; shift line valids cleared.
- hash0, data1, golden_nonce = 0.
REQ-030 rst during RUN or DRAIN discards all in-flight and buffered results; nothing is emitted after reset deasserts.

Configuration
REQ-031 Macro NONCE_SCHEDULER_TARGET_CMP_EN.
- Defined: the REQ-022 full compare applies.
- Undefined: golden when hash2[255:224] == 0 (difficulty-1 share); the target port is ignored and no target register is built.

Structure
REQ-032 Shared package holds:
- SHA-256 padding constants 32'h80000000 and 32'h00000280.
- The state enum.
- A nonce type of 32 bits.
REQ-033 One sub-module, nonce_fifo: synchronous valid/ready FIFO, parameterised width and depth, with a full flag.

Verification
REQ-034 Verification scenarios (bench model = hash stub with LATENCY = 4):
1. Range 5..7 -> data1 nonce field shows 5, 6, 7 in consecutive cycles; done pulses exactly once, 4+1+1 cycles after the last issue.
2. Range FFFFFFFE..00000001 -> 4 nonces issued, wrapping correctly.
3. Stub returns hash2 = target for nonce 6 and target+1 for the rest -> golden_nonce = 6 only.
4. golden_ready held low; FIFO_DEPTH+2 goldens -> first FIFO_DEPTH retained in order; drop pulses twice.
5. rst asserted mid-DRAIN with one golden pending -> golden_valid = 0 and work_ready = 1 on the next cycle; no later output.
6. Macro undefined: target = 0, hash2 = {32'h0, 224'hFF..F} -> reported golden.
